load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 146 ++++++++++++++
 tb/tb_load_store_unit.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding request, word-aligned bus with byte strobes,
// lane extraction/extension of load data, and a registered completion port.
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_store,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [4:0]       req_rd,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_wstrb,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic [4:0]       resp_rd,
    output logic             resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             armed;
    logic             accept;
    logic             illegal;
    logic [3:0]       store_strb;
    logic [WIDTH-1:0] store_data;
    logic [2:0]       ld_funct3;
    logic [1:0]       ld_off;
    logic [WIDTH-1:0] lane_shift;
    logic [7:0]       lane_byte;
    logic [15:0]      lane_half;
    logic [WIDTH-1:0] load_data;

    // Handshakes: a transfer happens on any rising edge where valid && ready.
    // Once raised, mem_valid and resp_valid stay high with stable payload until taken.
    assign req_ready  = armed && (state == IDLE);
    assign mem_valid  = (state == BUS);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;

    always_comb begin
        illegal = 1'b0;
        if (req_store) begin
            if (req_funct3 > 3'b010) illegal = 1'b1;
        end else if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111) begin
            illegal = 1'b1;
        end
        if (req_funct3[1:0] == 2'b01 && req_addr[0]) illegal = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) illegal = 1'b1;
    end

    always_comb begin
        store_strb = 4'b1111;
        store_data = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                store_strb = 4'b0001 << req_addr[1:0];
                store_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                store_strb = 4'b0011 << {req_addr[1], 1'b0};
                store_data = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection uses the offset latched at accept, not the live request.
    always_comb begin
        lane_shift = mem_rdata >> {ld_off, 3'b000};
        lane_byte  = lane_shift[7:0];
        lane_half  = ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ld_funct3)
            3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_data = {24'd0, lane_byte};
            3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_data = {16'd0, lane_half};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = illegal ? RESP : BUS;
            BUS:  if (mem_ready) state_next = mem_we ? RESP : WAIT;
            WAIT: if (mem_rvalid) state_next = RESP;
            RESP: if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= 4'd0;
            mem_wdata <= '0;
            resp_data <= '0;
            resp_rd   <= 5'd0;
            resp_err  <= 1'b0;
            ld_funct3 <= 3'd0;
            ld_off    <= 2'd0;
        end else if (accept) begin
            mem_we    <= req_store;
            mem_addr  <= {req_addr[WIDTH-1:2], 2'b00};
            mem_wstrb <= req_store ? store_strb : 4'd0;
            mem_wdata <= req_store ? store_data : '0;
            resp_data <= '0;
            resp_rd   <= req_store ? 5'd0 : req_rd;
            resp_err  <= illegal;
            ld_funct3 <= req_funct3;
            ld_off    <= req_addr[1:0];
        end else if (state == WAIT && mem_rvalid) begin
            resp_data <= load_data;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: driver issues requests and pushes expected bus
// and response records; a negedge monitor pops and compares on each handshake.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;

    load_store_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_err(resp_err)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass = 0;
    int n_resp = 0;
    int n_bus = 0;
    logic [37:0] exp_q[$];   // {err, rd, data}
    logic [68:0] bus_q[$];   // {we, addr, wstrb, wdata}

    int          cfg_ready_dly = 0;
    int          cfg_rvalid_dly = 0;
    int          cfg_resp_dly = 0;
    logic [31:0] cfg_rdata = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // bus and consumer responder, driven one step after each rising edge
    initial begin
        int   bus_cnt;
        int   wait_cnt;
        int   resp_cnt;
        logic in_wait;
        logic hs_load;
        logic took_rvalid;
        bus_cnt = 0; wait_cnt = 0; resp_cnt = 0; in_wait = 1'b0;
        forever begin
            @(negedge clk);
            hs_load     = mem_valid && mem_ready && !mem_we;
            took_rvalid = mem_rvalid;
            @(posedge clk);
            #1;
            if (mem_valid) begin
                mem_ready = (bus_cnt >= cfg_ready_dly);
                bus_cnt++;
            end else begin
                mem_ready = 1'b0;
                bus_cnt = 0;
            end
            if (took_rvalid) begin
                in_wait = 1'b0;
                mem_rvalid = 1'b0;
            end
            if (hs_load) begin
                in_wait = 1'b1;
                wait_cnt = 0;
            end
            if (in_wait) begin
                mem_rvalid = (wait_cnt >= cfg_rvalid_dly);
                mem_rdata = cfg_rdata;
                wait_cnt++;
            end
            if (resp_valid) begin
                resp_ready = (resp_cnt >= cfg_resp_dly);
                resp_cnt++;
            end else begin
                resp_ready = 1'b0;
                resp_cnt = 0;
            end
        end
    end

    // scoreboard monitor
    logic        held_mem = 1'b0;
    logic        held_resp = 1'b0;
    logic [68:0] h_bus;
    logic [37:0] h_resp;
    logic [68:0] m_bus;
    logic [37:0] m_resp;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_valid) n_bus++;
            if (held_mem && mem_valid) begin
                check("mem_hold_addr", mem_addr, h_bus[67:36]);
                check("mem_hold_wdata", mem_wdata, h_bus[31:0]);
                check("mem_hold_we_strb", {27'd0, mem_we, mem_wstrb}, {27'd0, h_bus[68], h_bus[35:32]});
            end
            if (mem_valid && mem_ready) begin
                if (bus_q.size() == 0) begin
                    check("bus_unexpected", 32'(bus_q.size()), 32'd1);
                end else begin
                    m_bus = bus_q.pop_front();
                    check("bus_addr", mem_addr, m_bus[67:36]);
                    check("bus_wdata", mem_wdata, m_bus[31:0]);
                    check("bus_we_strb", {27'd0, mem_we, mem_wstrb}, {27'd0, m_bus[68], m_bus[35:32]});
                end
            end
            held_mem = mem_valid && !mem_ready;
            h_bus = {mem_we, mem_addr, mem_wstrb, mem_wdata};

            if (held_resp && resp_valid) begin
                check("resp_hold", {resp_err, resp_rd, resp_data[25:0]}, {h_resp[37], h_resp[36:32], h_resp[25:0]});
                check("resp_hold_data", resp_data, h_resp[31:0]);
            end
            if (resp_valid && resp_ready) begin
                n_resp++;
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    m_resp = exp_q.pop_front();
                    check("resp_data", resp_data, m_resp[31:0]);
                    check("resp_rd", {27'd0, resp_rd}, {27'd0, m_resp[36:32]});
                    check("resp_err", {31'd0, resp_err}, {31'd0, m_resp[37]});
                end
            end
            held_resp = resp_valid && !resp_ready;
            h_resp = {resp_err, resp_rd, resp_data};
        end
    end

    // driver tasks; all start and end one step after a rising edge
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, output int acc);
        logic got;
        got = 1'b0;
        acc = -1;
        req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
        req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                acc = cyc;
                break;
            end
        end
        check("accept_timeout", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        // scramble the request fields so any late sampling shows up on the bus
        req_valid = 1'b0;
        req_wdata = ~wd;
        req_addr = a ^ 32'hFFFF_FFF3;
        req_funct3 = ~f3;
        req_rd = ~rd;
    endtask

    task automatic wait_resp(input string name, input int acc, input int lat, output int hs);
        int   first;
        logic done;
        first = -1;
        done = 1'b0;
        hs = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (resp_valid && first < 0) first = cyc;
            if (resp_valid) check({name, "_req_ready_low"}, {31'd0, req_ready}, 32'd0);
            if (resp_valid && resp_ready) begin
                hs = cyc;
                done = 1'b1;
                break;
            end
        end
        check({name, "_resp_timeout"}, {31'd0, done}, 32'd1);
        if (done) check({name, "_latency"}, 32'(first - acc), 32'(lat));
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input string name, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] rdata, input int rdy_dly, input int rsp_dly,
                       input logic exp_bus, input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                       input logic [31:0] exp_wdata, input logic [4:0] exp_rd,
                       input logic [31:0] exp_data, input int lat, output int acc, output int hs);
        int nb0;
        cfg_rdata = rdata;
        cfg_ready_dly = rdy_dly;
        cfg_resp_dly = rsp_dly;
        cfg_rvalid_dly = 0;
        exp_q.push_back({~exp_bus, exp_rd, exp_data});
        if (exp_bus) bus_q.push_back({st, exp_addr, exp_strb, exp_wdata});
        nb0 = n_bus;
        issue(st, f3, a, wd, rd, acc);
        wait_resp(name, acc, lat, hs);
        if (!exp_bus) check({name, "_no_bus"}, 32'(n_bus - nb0), 32'd0);
    endtask

    task automatic wait_to(input int target);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cyc >= target) break;
        end
    endtask

    // called at a falling edge: pulse reset between edges, then watch the unit stay quiet
    task automatic pulse_reset(input string name);
        int   r0;
        logic busy;
        #1 rst_n = 1'b0;
        #1;
        check({name, "_mem_valid"}, {31'd0, mem_valid}, 32'd0);
        check({name, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        check({name, "_req_ready"}, {31'd0, req_ready}, 32'd0);
        check({name, "_resp_data"}, resp_data, 32'd0);
        #1 rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check({name, "_ready_after"}, {31'd0, req_ready}, 32'd1);
        r0 = n_resp;
        busy = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            busy = busy | mem_valid | resp_valid;
        end
        check({name, "_quiet"}, {31'd0, busy}, 32'd0);
        check({name, "_no_resp"}, 32'(n_resp - r0), 32'd0);
        check({name, "_idle"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int hs;
        int hs_g;

        // reset state
        @(negedge clk);
        check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_rd", {27'd0, resp_rd}, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_first_edge", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;

        //  name    st  f3      addr          wdata         rd     rdata         rdy rsp bus addr          strb     wdata         erd    edata         lat
        txn("sb",   1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 5'd7,  32'h0,        0, 0, 1, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 5'd0,  32'h0,        2, acc, hs);
        txn("lb",   0, 3'b000, 32'h0000_2002, 32'h0,        5'd9,  32'h0080_0000, 0, 0, 1, 32'h0000_2000, 4'b0000, 32'h0,        5'd9,  32'hFFFF_FF80, 3, acc, hs);
        txn("lbu",  0, 3'b100, 32'h0000_2002, 32'h0,        5'd9,  32'h0080_0000, 0, 0, 1, 32'h0000_2000, 4'b0000, 32'h0,        5'd9,  32'h0000_0080, 3, acc, hs);
        txn("lh_mis", 0, 3'b001, 32'h0000_3001, 32'h0,      5'd3,  32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        5'd3,  32'h0,        1, acc, hs);
        txn("ld011", 0, 3'b011, 32'h0000_3000, 32'h0,       5'd4,  32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        5'd4,  32'h0,        1, acc, hs);
        txn("sw_stall", 1, 3'b010, 32'h0000_4000, 32'h1234_5678, 5'd1, 32'h0,    3, 0, 1, 32'h0000_4000, 4'b1111, 32'h1234_5678, 5'd0, 32'h0,        5, acc, hs);
        txn("lw_hold", 0, 3'b010, 32'h0000_5004, 32'h0,     5'd31, 32'hDEAD_BEEF, 0, 2, 1, 32'h0000_5004, 4'b0000, 32'h0,        5'd31, 32'hDEAD_BEEF, 3, acc, hs_g);
        txn("sh_next", 1, 3'b001, 32'h0000_6002, 32'h0000_BEEF, 5'd2, 32'h0,     0, 0, 1, 32'h0000_6000, 4'b1100, 32'hBEEF_BEEF, 5'd0, 32'h0,        2, acc, hs);
        check("accept_after_resp", 32'(acc - hs_g), 32'd1);
        txn("lh",   0, 3'b001, 32'h0000_7002, 32'h0,        5'd10, 32'h8001_7FFF, 0, 0, 1, 32'h0000_7000, 4'b0000, 32'h0,        5'd10, 32'hFFFF_8001, 3, acc, hs);
        txn("lhu",  0, 3'b101, 32'h0000_7000, 32'h0,        5'd11, 32'h8001_7FFF, 0, 0, 1, 32'h0000_7000, 4'b0000, 32'h0,        5'd11, 32'h0000_7FFF, 3, acc, hs);
        txn("st011", 1, 3'b011, 32'h0000_8000, 32'h0,       5'd8,  32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        5'd0,  32'h0,        1, acc, hs);
        txn("sw_mis", 1, 3'b010, 32'h0000_8002, 32'h0,      5'd8,  32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        5'd0,  32'h0,        1, acc, hs);
        txn("lw_mis", 0, 3'b010, 32'h0000_8001, 32'h0,      5'd5,  32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        5'd5,  32'h0,        1, acc, hs);
        txn("sb_lane1", 1, 3'b000, 32'h0000_9001, 32'h0000_00C3, 5'd6, 32'h0,    0, 0, 1, 32'h0000_9000, 4'b0010, 32'hC3C3_C3C3, 5'd0, 32'h0,        2, acc, hs);

        // reset while the bus request is stalled
        cfg_ready_dly = 8;
        issue(1'b1, 3'b010, 32'h0000_A000, 32'h5555_AAAA, 5'd0, acc);
        wait_to(acc + 2);
        check("rst_bus_pre", {31'd0, mem_valid}, 32'd1);
        pulse_reset("rst_bus");

        // reset while waiting for read data, with rvalid arriving afterwards
        cfg_ready_dly = 0;
        cfg_rvalid_dly = 3;
        cfg_rdata = 32'h7777_7777;
        bus_q.push_back({1'b0, 32'h0000_B000, 4'b0000, 32'h0});
        issue(1'b0, 3'b010, 32'h0000_B000, 32'h0, 5'd6, acc);
        wait_to(acc + 2);
        check("rst_wait_pre", {31'd0, mem_valid | resp_valid}, 32'd0);
        pulse_reset("rst_wait");
        cfg_rvalid_dly = 0;

        // reset while a response is waiting to be taken
        cfg_resp_dly = 8;
        cfg_rdata = 32'h1111_1111;
        bus_q.push_back({1'b0, 32'h0000_C000, 4'b0000, 32'h0});
        issue(1'b0, 3'b010, 32'h0000_C000, 32'h0, 5'd13, acc);
        wait_to(acc + 3);
        check("rst_resp_pre", {31'd0, resp_valid}, 32'd1);
        pulse_reset("rst_resp");

        txn("lb_after", 0, 3'b000, 32'h0000_9001, 32'h0,    5'd12, 32'h0000_FE00, 0, 0, 1, 32'h0000_9000, 4'b0000, 32'h0,        5'd12, 32'hFFFF_FFFE, 3, acc, hs);

        repeat (3) @(negedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("bus_q_empty", 32'(bus_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
